// File: rtl/task_grant_responder.sv
// Task-side responder: one job per task, drives req/res_need to the priority controller and
// consumes its one-hot grant. Optional starvation monitor enabled by defining STARVATION_MON_EN.
module task_grant_responder #(
    parameter int NUM_TASKS     = 4,
    parameter int TASK_ID_WIDTH = $clog2(NUM_TASKS),
    parameter int LEN_WIDTH     = 8,
    parameter int STARVE_LIMIT  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [TASK_ID_WIDTH-1:0] job_task,
    input  logic [LEN_WIDTH-1:0]     job_len,
    input  logic                     job_res,
    output logic [NUM_TASKS-1:0]     req,
    output logic [NUM_TASKS-1:0]     res_need,
    input  logic [NUM_TASKS-1:0]     grant,
    output logic [NUM_TASKS-1:0]     busy,
    output logic                     done_valid,
    output logic [TASK_ID_WIDTH-1:0] done_task,
    output logic                     error,
    output logic [NUM_TASKS-1:0]     starve
);

    // Job handshake: a job is taken when job_valid && job_ready; job_ready is low only while
    // the addressed task still holds an unfinished job.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e                   state_q [NUM_TASKS];
    state_e                   state_d [NUM_TASKS];
    logic [LEN_WIDTH-1:0]     rem_q   [NUM_TASKS];
    logic [LEN_WIDTH-1:0]     rem_d   [NUM_TASKS];
    logic [NUM_TASKS-1:0]     res_q, res_d;
    logic                     done_valid_q, done_valid_d;
    logic [TASK_ID_WIDTH-1:0] done_task_q, done_task_d;
    logic                     error_q, error_d;

    logic [NUM_TASKS-1:0]     idle_mask;
    logic [NUM_TASKS-1:0]     grant_m1;
    logic                     grant_valid;
    logic                     accept;

    always_comb begin
        idle_mask = '0;
        for (int t = 0; t < NUM_TASKS; t++) begin
            idle_mask[t] = (state_q[t] == ST_IDLE);
        end
    end

    assign busy      = ~idle_mask;
    assign req       = busy;
    assign res_need  = res_q & busy;
    assign job_ready = !busy[job_task];
    assign accept    = job_valid && job_ready;

    // x & (x-1) is nonzero exactly when more than one bit of x is set.
    assign grant_m1    = grant - NUM_TASKS'(1);
    assign grant_valid = ~|(grant & grant_m1) && ~|(grant & idle_mask);

    always_comb begin
        res_d        = res_q;
        done_valid_d = 1'b0;
        done_task_d  = done_task_q;
        error_d      = error_q | ~grant_valid;
        for (int t = 0; t < NUM_TASKS; t++) begin
            state_d[t] = state_q[t];
            rem_d[t]   = rem_q[t];
            case (state_q[t])
                ST_IDLE: begin
                    if (accept && (job_task == TASK_ID_WIDTH'(t))) begin
                        state_d[t] = ST_WAIT;
                        rem_d[t]   = (job_len == '0) ? LEN_WIDTH'(1) : job_len;
                        res_d[t]   = job_res;
                    end
                end
                ST_WAIT, ST_RUN: begin
                    // An invalid grant freezes every task for that cycle.
                    if (grant_valid && grant[t]) begin
                        if (rem_q[t] == LEN_WIDTH'(1)) begin
                            state_d[t]   = ST_IDLE;
                            res_d[t]     = 1'b0;
                            done_valid_d = 1'b1;
                            done_task_d  = TASK_ID_WIDTH'(t);
                        end else begin
                            state_d[t] = ST_RUN;
                            rem_d[t]   = rem_q[t] - LEN_WIDTH'(1);
                        end
                    end else if (grant_valid) begin
                        state_d[t] = ST_WAIT;
                    end
                end
                default: state_d[t] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_TASKS; t++) begin
                state_q[t] <= ST_IDLE;
                rem_q[t]   <= '0;
            end
            res_q        <= '0;
            done_valid_q <= 1'b0;
            done_task_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            for (int t = 0; t < NUM_TASKS; t++) begin
                state_q[t] <= state_d[t];
                rem_q[t]   <= rem_d[t];
            end
            res_q        <= res_d;
            done_valid_q <= done_valid_d;
            done_task_q  <= done_task_d;
            error_q      <= error_d;
        end
    end

    assign done_valid = done_valid_q;
    assign done_task  = done_task_q;
    assign error      = error_q;

`ifdef STARVATION_MON_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]     wait_cnt_q [NUM_TASKS];
    logic [CNT_W-1:0]     wait_cnt_d [NUM_TASKS];
    logic [NUM_TASKS-1:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        for (int t = 0; t < NUM_TASKS; t++) begin
            wait_cnt_d[t] = wait_cnt_q[t];
            if ((state_q[t] == ST_IDLE) || (grant_valid && grant[t])) begin
                wait_cnt_d[t] = '0;
                starve_d[t]   = 1'b0;
            end else begin
                if ((state_q[t] == ST_WAIT) && !grant[t] &&
                    (wait_cnt_q[t] != CNT_W'(STARVE_LIMIT))) begin
                    wait_cnt_d[t] = wait_cnt_q[t] + CNT_W'(1);
                end
                if (wait_cnt_q[t] == CNT_W'(STARVE_LIMIT)) begin
                    starve_d[t] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_TASKS; t++) begin
                wait_cnt_q[t] <= '0;
            end
            starve_q <= '0;
        end else begin
            for (int t = 0; t < NUM_TASKS; t++) begin
                wait_cnt_q[t] <= wait_cnt_d[t];
            end
            starve_q <= starve_d;
        end
    end

    assign starve = starve_q;
`else
    assign starve = '0;
`endif

endmodule
